// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between ICache and DCache.
// One line transaction at a time: IDLE -> ISSUE -> RESP -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              data_filled_ackI,
    output logic              mem_data_rdyI,
    output logic [LINE_W-1:0] instr_from_mem,
    input  logic              reqD_mem,
    input  logic              reqWrD_mem,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] reqDataD_mem,
    input  logic              data_filled_ackD,
    output logic              mem_data_rdyD,
    output logic [LINE_W-1:0] data_from_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_q;

    logic any_req;
    logic grant_d;
    logic owner_ack;

    // owner_q / last_q: 1 = DCache, 0 = ICache
    assign any_req   = reqI_mem | reqD_mem;
    assign grant_d   = reqD_mem & (~reqI_mem | ~last_q);
    assign owner_ack = owner_q ? data_filled_ackD : data_filled_ackI;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req)   state_d = ISSUE;
            ISSUE:   if (mem_ack)   state_d = RESP;
            RESP:    if (owner_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request; later requester changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q <= grant_d;
            last_q  <= grant_d;
            we_q    <= grant_d & reqWrD_mem;
            addr_q  <= grant_d ? reqAddrD_mem : reqAddrI_mem;
            wdata_q <= grant_d ? reqDataD_mem : '0;
        end
    end

    // Capture read data on the memory ack; writes leave the line alone
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else if (state_q == ISSUE && mem_ack && !we_q) begin
            line_q <= mem_rdata;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy           = (state_q != IDLE);
        mem_req        = (state_q == ISSUE);
        mem_we         = (state_q == ISSUE) & we_q;
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        mem_data_rdyI  = (state_q == RESP) & ~owner_q;
        mem_data_rdyD  = (state_q == RESP) & owner_q;
        instr_from_mem = line_q;
        data_from_mem  = line_q;
    end

endmodule
